serial_add_unit: RTL and testbench
==================================

// Module: serial_add_unit
// PURPOSE
//   Bit-serial add/subtract engine built around the 1-bit full-adder cell.
//   Loads two WIDTH-bit operands, feeds one bit pair plus a registered carry per cycle
//   through the full-adder equations (LSB first), and shifts the sum bits into a result register.
//   Used as the low-area multi-cycle ALU add path. Results go to writeback through a start/done handshake.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>=2)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request; sampled only in IDLE
//   sub        in   1      0: a+b, 1: a-b (b inverted, carry-in=1); sampled with start
//   a          in   WIDTH  operand A; sampled with start
//   b          in   WIDTH  operand B; sampled with start
//   busy       out  1      high while bits are being processed (RUN)
//   done       out  1      one-cycle pulse: result/flags valid
//   result     out  WIDTH  sum/difference; held until next accepted start
//   carry_out  out  1      carry out of MSB (sub: 1 = no borrow)
//   overflow   out  1      signed overflow = carry into MSB XOR carry out of MSB
//   zero       out  1      result == 0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0,
//     zero=0. Shift registers, carry flop and bit counter are cleared.
//   FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on an edge with start=1:
//     - load opA=a, opB = sub ? ~b : b
//     - carry=sub, cnt=0, go to RUN
//     - result/flags are not cleared at load; they hold their previous values until DONE.
//   RUN: each edge processes the LSB pair:
//     - s = opA[0]^opB[0]^carry
//     - c = opA[0]&opB[0] | carry&(opA[0]|opB[0])
//     - opA, opB shift right by 1; s enters the result shift register at the MSB and shifts right
//     - carry<=c, cnt<=cnt+1
//     - on the edge where cnt==WIDTH-2, also capture the current carry as c_msb_in
//       (carry into the MSB)
//     - after the WIDTH-th RUN edge (cnt==WIDTH-1) go to DONE
//   DONE: lasts exactly one cycle, then IDLE.
//     - done=1; result/carry_out/overflow/zero are registered on the same edge entering DONE
//   Latency: start sampled at edge E0; done is high in the cycle following edge E0+WIDTH;
//     busy is high for exactly WIDTH cycles.
//   Throughput: the next start can be accepted on the edge that leaves DONE+1, i.e. in IDLE only.
//   start is ignored in RUN and DONE, and a/b/sub changes there have no effect.
//   Arithmetic is modulo 2^WIDTH; no saturation.
//   sub=1 gives a + ~b + 1 (two's complement).
//   Reset mid-operation aborts immediately; no done pulse is generated for the aborted op.
//   Counter width is clog2(WIDTH); it never wraps beyond WIDTH-1.
// TESTING (WIDTH=32 unless stated)
//   1. start, a=5, b=3, sub=0 at E0 -> busy for 32 cycles; done pulse after E0+32;
//      result=8, carry_out=0, overflow=0, zero=0.
//   2. a=0xFFFFFFFF, b=1, sub=0 -> result=0, carry_out=1, overflow=0, zero=1.
//   3. a=0x7FFFFFFF, b=1, sub=0 -> result=0x80000000, carry_out=0, overflow=1.
//   4. a=5, b=7, sub=1 -> result=0xFFFFFFFE, carry_out=0 (borrow), overflow=0;
//      a=7, b=7, sub=1 -> result=0, carry_out=1, zero=1.
//   5. start held high for 40 cycles with a/b toggling -> only the first operands are used;
//      the second op begins from IDLE after DONE; done is a 1-cycle pulse each time.
//   6. rst_n low at cycle 10 of RUN -> all outputs 0 at once, no done pulse;
//      after release, a=1, b=1 completes normally with result=2.
//   Also run WIDTH=8: a=0x80, b=0x80 -> result=0, carry_out=1, overflow=1, done after E0+8.

Source files
------------

// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial add/subtract engine, one full-adder step per cycle, LSB first.
module serial_add_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN = CW'(WIDTH - 2);
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opa, r_opb, r_sum, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cmsb, r_cout, r_ovf, r_zero;
  logic             w_s, w_c;
  logic [WIDTH-1:0] w_sum;
  assign w_s = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_c = (r_opa[0] & r_opb[0]) | (r_carry & (r_opa[0] | r_opb[0]));
  assign w_sum = {w_s, r_sum[WIDTH-1:1]};
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign result = r_result;
  assign carry_out = r_cout;
  assign overflow = r_ovf;
  assign zero = r_zero;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_sum    <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_cmsb   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_opa   <= a;
          r_opb   <= sub ? ~b : b;
          r_carry <= sub;
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_sum   <= w_sum;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == PEN) r_cmsb <= w_c;
          // Final bit: publish the completed sum and flags as the FSM enters DONE
          if (r_cnt == LAST) begin
            r_cnt    <= '0;
            r_state  <= DONE;
            r_result <= w_sum;
            r_cout   <= w_c;
            r_ovf    <= r_cmsb ^ w_c;
            r_zero   <= ~|w_sum;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_unit.sv
// tb_serial_add_unit: scoreboard bench for 32-bit and 8-bit serial adders.
module tb_serial_add_unit;
  typedef struct {
    logic [31:0] res;
    logic        c, v, z;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start32 = 1'b0, sub32 = 1'b0, start8 = 1'b0, sub8 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy32, done32, cout32, ovf32, zero32;
  logic        busy8, done8, cout8, ovf8, zero8;
  logic [31:0] res32;
  logic [7:0]  res8;
  exp_t        q32[$], q8[$];
  int          cyc = 0, n_vec = 0, n_err = 0;
  int          bc32 = 0, bc8 = 0;
  logic        pd32 = 1'b0, pd8 = 1'b0;

  serial_add_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .carry_out(cout32),
    .overflow(ovf32), .zero(zero32)
  );

  serial_add_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .carry_out(cout8),
    .overflow(ovf8), .zero(zero8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got done=1 expected no pulse", nm);
  endtask

  // Monitor: pops an expectation whenever a done pulse is presented
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bc32 = 0;
      bc8 = 0;
      pd32 = 1'b0;
      pd8 = 1'b0;
    end else begin
      if (busy32) bc32++;
      if (busy8) bc8++;
      if (done32) begin
        chk("done32_width", 32'(pd32), 32'd0);
        if (q32.size() == 0) unexpected("unexpected_done32");
        else begin
          e = q32.pop_front();
          chk("res32", res32, e.res);
          chk("cout32", 32'(cout32), 32'(e.c));
          chk("ovf32", 32'(ovf32), 32'(e.v));
          chk("zero32", 32'(zero32), 32'(e.z));
          chk("lat32", 32'(cyc), 32'(e.cyc));
          chk("busy32_len", 32'(bc32), 32'd32);
        end
        bc32 = 0;
      end
      if (done8) begin
        chk("done8_width", 32'(pd8), 32'd0);
        if (q8.size() == 0) unexpected("unexpected_done8");
        else begin
          e = q8.pop_front();
          chk("res8", 32'(res8), e.res);
          chk("cout8", 32'(cout8), 32'(e.c));
          chk("ovf8", 32'(ovf8), 32'(e.v));
          chk("zero8", 32'(zero8), 32'(e.z));
          chk("lat8", 32'(cyc), 32'(e.cyc));
          chk("busy8_len", 32'(bc8), 32'd8);
        end
        bc8 = 0;
      end
      pd32 = done32;
      pd8 = done8;
    end
  end

  task automatic drain();
    for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    if (q32.size() != 0 || q8.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d/%0d pending expected 0", q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
  endtask

  task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input logic [31:0] r, input logic c, input logic v, input logic z);
    @(negedge clk);
    a32 = x; b32 = y; sub32 = s; start32 = 1'b1;
    q32.push_back('{r, c, v, z, cyc + 33});
    @(negedge clk);
    start32 = 1'b0;
    a32 = ~x; b32 = ~y; sub32 = ~s;
    drain();
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                     input logic [7:0] r, input logic c, input logic v, input logic z);
    @(negedge clk);
    a8 = x; b8 = y; sub8 = s; start8 = 1'b1;
    q8.push_back('{32'(r), c, v, z, cyc + 9});
    @(negedge clk);
    start8 = 1'b0;
    drain();
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_busy32"}, 32'(busy32), 32'd0);
    chk({nm, "_done32"}, 32'(done32), 32'd0);
    chk({nm, "_res32"}, res32, 32'd0);
    chk({nm, "_flags32"}, {29'd0, cout32, ovf32, zero32}, 32'd0);
    chk({nm, "_res8"}, 32'(res8), 32'd0);
    chk({nm, "_flags8"}, {28'd0, busy8, cout8, ovf8, zero8}, 32'd0);
  endtask

  initial begin
    #1 chk_reset("reset");
    #20 rst_n = 1'b1;
    op32(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0);
    op32(32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
    op32(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    op32(32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    op32(32'd7, 32'd7, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
    op32(32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    // start held high: only operands at the first and the post-DONE accept edge matter
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start32 = 1'b1;
      sub32 = k[0];
      a32 = (k == 0) ? 32'h11111111 : (k == 34) ? 32'h00000100 : 32'hDEAD0000 | 32'(k);
      b32 = (k == 0) ? 32'h22222222 : (k == 34) ? 32'h00000200 : 32'h0BEE0000 | 32'(k);
      if (k == 0) q32.push_back('{32'h33333333, 1'b0, 1'b0, 1'b0, cyc + 33});
      if (k == 34) q32.push_back('{32'h00000300, 1'b0, 1'b0, 1'b0, cyc + 33});
    end
    @(negedge clk);
    start32 = 1'b0;
    drain();
    // abort mid-run: no expectation pushed, so any done pulse is flagged
    @(negedge clk);
    a32 = 32'h12345678; b32 = 32'd1; sub32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op32(32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    op8(8'h0F, 8'h10, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
